pulse_meter: RTL and testbench

Receive-side companion to the bench pulse and trigger generators. It synchronizes an asynchronous pulse-train input and detects its edges. It measures the last high width and the last low gap in clock cycles, and counts the pulses in a burst. When the line has been idle for GAP cycles it reports the results with a one-cycle valid strobe. It sits between any pulse source and the checking logic.

---
 rtl/pulse_meter_if.sv | 23 ++
 rtl/pulse_meter.sv | 113 +++++++++++
 tb/tb_pulse_meter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pulse_meter_if.sv
// Pulse-meter bus: raw pulse input and enable in, burst measurements and strobes out.
interface pulse_meter_if #(
    parameter int WIDTH = 8
);
    logic             signal;
    logic             on;
    logic [WIDTH-1:0] high_len;
    logic [WIDTH-1:0] low_len;
    logic [3:0]       count;
    logic             valid;
    logic             busy;
    logic             overflow;

    modport master (
        output signal, on,
        input  high_len, low_len, count, valid, busy, overflow
    );

    modport slave (
        input  signal, on,
        output high_len, low_len, count, valid, busy, overflow
    );
endinterface

// File: rtl/pulse_meter.sv
// Synchronizes a raw pulse train, measures last high/low widths and pulse count per burst,
// and strobes valid once the line has stayed low for GAP cycles after a fall.
module pulse_meter #(
    parameter int WIDTH = 8,
    parameter int GAP   = 16
) (
    input  logic          clock,
    input  logic          reset,
    pulse_meter_if.slave  pm
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, REPORT} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] GAP_C   = WIDTH'(GAP);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic [WIDTH-1:0] hlen_q, hlen_d, llen_q, llen_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             rise, fall;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= IDLE;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
            hlen_q  <= '0;
            llen_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            s1_q    <= pm.signal;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
            hlen_q  <= hlen_d;
            llen_q  <= llen_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        hlen_d  = hlen_q;
        llen_d  = llen_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (rise && pm.on) begin
                    state_d = HIGH;
                    hcnt_d  = WIDTH'(1);
                    lcnt_d  = '0;
                    cnt_d   = 4'd1;
                    ovf_d   = 1'b0;
                    hlen_d  = '0;
                    llen_d  = '0;
                end
            end
            HIGH: begin
                if (!pm.on) begin
                    state_d = IDLE;
                end else if (fall) begin
                    hlen_d  = hcnt_q;
                    lcnt_d  = WIDTH'(1);
                    state_d = LOW;
                end else if (s2_q && s3_q) begin
                    if (hcnt_q == CNT_MAX) ovf_d = 1'b1;
                    else                   hcnt_d = hcnt_q + 1'b1;
                end
            end
            LOW: begin
                // A rise on the GAP-th low cycle still extends the burst.
                if (!pm.on) begin
                    state_d = IDLE;
                end else if (rise) begin
                    llen_d  = lcnt_q;
                    hcnt_d  = WIDTH'(1);
                    state_d = HIGH;
                    if (cnt_q == 4'hF) ovf_d = 1'b1;
                    else               cnt_d = cnt_q + 1'b1;
                end else if (lcnt_q == GAP_C && !s2_q) begin
                    state_d = REPORT;
                end else if (!s2_q && !s3_q) begin
                    if (lcnt_q == CNT_MAX) ovf_d = 1'b1;
                    else                   lcnt_d = lcnt_q + 1'b1;
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pm.high_len = hlen_q;
    assign pm.low_len  = llen_q;
    assign pm.count    = cnt_q;
    assign pm.overflow = ovf_q;
    assign pm.valid    = (state_q == REPORT);
    assign pm.busy     = (state_q == HIGH) || (state_q == LOW);
endmodule

// File: tb/tb_pulse_meter.sv
// Drives bursts of known pulse/gap lengths and checks the reported results against
// values computed directly from those lengths.
module tb_pulse_meter;
    localparam int W    = 8;
    localparam int G    = 16;
    localparam int MAXV = (1 << W) - 1;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0, nvalid = 0, noverlap = 0, tests = 0, fails = 0;
    int   hq[$], lq[$];

    pulse_meter_if #(.WIDTH(W)) bus ();
    pulse_meter #(.WIDTH(W), .GAP(G)) dut (.clock(clock), .reset(reset), .pm(bus.slave));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (bus.valid) nvalid++;
        if (bus.valid && bus.busy) noverlap++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ncyc(input int k);
        repeat (k) @(negedge clock);
    endtask

    // Drives hq/lq as one burst; expectations come from the lengths alone.
    task automatic run_burst(input string tag);
        int n, a, ecnt, ehl, ell, eovf;
        n    = hq.size();
        ecnt = (n > 15) ? 15 : n;
        ehl  = (hq[n-1] > MAXV) ? MAXV : hq[n-1];
        ell  = (n > 1) ? lq[n-2] : 0;
        eovf = (n > 15) ? 1 : 0;
        foreach (hq[i]) if (hq[i] > MAXV) eovf = 1;
        nvalid = 0;
        for (int i = 0; i < n; i++) begin
            bus.signal = 1'b1;
            ncyc(hq[i]);
            bus.signal = 1'b0;
            if (i < n - 1) ncyc(lq[i]);
        end
        a = cyc + 1;
        ncyc(G + 2);
        chk({tag, ".busy_pre"},  bus.busy,  1);
        chk({tag, ".valid_pre"}, bus.valid, 0);
        ncyc(1);
        chk({tag, ".valid_at"},  bus.valid, (cyc == a + G + 2) ? 1 : 0);
        chk({tag, ".busy_at"},   bus.busy,  0);
        ncyc(4);
        chk({tag, ".nvalid"},   nvalid,       1);
        chk({tag, ".count"},    bus.count,    ecnt);
        chk({tag, ".high_len"}, bus.high_len, ehl);
        chk({tag, ".low_len"},  bus.low_len,  ell);
        chk({tag, ".overflow"}, bus.overflow, eovf);
    endtask

    initial begin
        reset = 1'b1;
        bus.signal = 1'b0;
        bus.on = 1'b1;
        ncyc(3);
        chk("rst.high_len", bus.high_len, 0);
        chk("rst.low_len",  bus.low_len,  0);
        chk("rst.count",    bus.count,    0);
        chk("rst.valid",    bus.valid,    0);
        chk("rst.busy",     bus.busy,     0);
        chk("rst.overflow", bus.overflow, 0);
        reset = 1'b0;
        ncyc(3);

        hq = {3, 3};   lq = {3};      run_burst("basic");
        hq = {5};      lq.delete();   run_burst("single");
        hq = {300};    lq.delete();   run_burst("sat_high");
        hq = {255};    lq.delete();   run_burst("max_high");
        hq.delete(); lq.delete();
        for (int i = 0; i < 17; i++) begin
            hq.push_back(2);
            if (i < 16) lq.push_back(2);
        end
        run_burst("sat_count");
        hq = {3, 3};   lq = {G - 1};  run_burst("gap_m1");
        hq = {3, 4};   lq = {G};      run_burst("gap_eq");
        hq = {1, 1};   lq = {1};      run_burst("min_len");

        // Gap of GAP+2 low samples splits into two single-pulse bursts.
        nvalid = 0;
        bus.signal = 1'b1; ncyc(3);
        bus.signal = 1'b0; ncyc(G + 2);
        bus.signal = 1'b1; ncyc(3);
        bus.signal = 1'b0; ncyc(G + 8);
        chk("gap_p2.nvalid",  nvalid,       2);
        chk("gap_p2.count",   bus.count,    1);
        chk("gap_p2.low_len", bus.low_len,  0);

        // Enable raised mid-pulse: nothing starts without a fresh rise.
        nvalid = 0;
        bus.on = 1'b0; bus.signal = 1'b1; ncyc(3);
        bus.on = 1'b1; ncyc(3);
        chk("en_mid.busy", bus.busy, 0);
        bus.signal = 1'b0; ncyc(G + 6);
        chk("en_mid.nvalid", nvalid, 0);
        chk("en_mid.count",  bus.count, 1);
        hq = {4};      lq.delete();   run_burst("en_next");

        // Enable dropped in LOW: abort, keep partial results.
        nvalid = 0;
        bus.signal = 1'b1; ncyc(6);
        bus.signal = 1'b0; ncyc(5);
        chk("en_low.busy_pre", bus.busy, 1);
        bus.on = 1'b0; ncyc(1);
        chk("en_low.busy", bus.busy, 0);
        bus.on = 1'b1; ncyc(G + 6);
        chk("en_low.nvalid",   nvalid,       0);
        chk("en_low.count",    bus.count,    1);
        chk("en_low.high_len", bus.high_len, 6);

        for (int b = 0; b < 12; b++) begin
            int n;
            n = $urandom_range(1, 6);
            hq.delete(); lq.delete();
            for (int i = 0; i < n; i++) begin
                hq.push_back($urandom_range(1, 12));
                if (i < n - 1) lq.push_back($urandom_range(1, G));
            end
            run_burst($sformatf("rnd%0d", b));
        end

        // Asynchronous reset between clock edges while in HIGH.
        hq = {2, 2};   lq = {2};      run_burst("pre_rst");
        nvalid = 0;
        bus.signal = 1'b1; ncyc(6);
        chk("arst.busy_pre", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst.busy",     bus.busy,     0);
        chk("arst.count",    bus.count,    0);
        chk("arst.high_len", bus.high_len, 0);
        chk("arst.overflow", bus.overflow, 0);
        bus.signal = 1'b0;
        ncyc(3);
        reset = 1'b0;
        ncyc(G + 6);
        chk("arst.nvalid", nvalid, 0);
        chk("arst.count_after", bus.count, 0);

        chk("valid_busy_overlap", noverlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
